// File: rtl/aibcr3aux_por_seq_master.sv
// AUX master POR sequencer: syncs/debounces detect and por, releases global then staggered per-channel PORs.
// Optional detect-loss fault statistics are built when AIBCR3AUX_POR_FAULT_STAT_EN is defined.
module aibcr3aux_por_seq_master #(
  parameter int NUM_CH      = 24,
  parameter int DBNC_CYC    = 200,
  parameter int STAGGER_CYC = 4
) (
  input  logic              i_osc_clk,
  input  logic              i_rst_n,
  input  logic              i_device_detect,
  input  logic              i_por_pad,
  input  logic              m_por_ovrd,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic              osc_clkout,
  output logic              o_por_vcchssi,
  output logic              o_por_vccl,
  output logic [NUM_CH-1:0] o_ch_por,
  output logic              o_dev_det,
  output logic              o_seq_done,
  output logic [2:0]        o_state,
  output logic              o_fault,
  output logic [7:0]        o_fault_cnt
);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam int SW = $clog2(STAGGER_CYC + 1);
  localparam int DW = $clog2(DBNC_CYC + 1);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_WAIT_DET = 3'd1,
    S_WAIT_POR = 3'd2,
    S_RELEASE  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              det_s1, det_s2, por_s1, por_s2;
  logic              dev_det;
  logic [DW-1:0]     dbnc_cnt;
  logic [CW-1:0]     ch_idx, ch_idx_nxt;
  logic [SW-1:0]     slot_cnt, slot_nxt;
  logic [NUM_CH-1:0] released, released_nxt;

  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      det_s1 <= 1'b0;
      det_s2 <= 1'b0;
      por_s1 <= 1'b0;
      por_s2 <= 1'b0;
    end else begin
      det_s1 <= i_device_detect;
      det_s2 <= det_s1;
      por_s1 <= i_por_pad;
      por_s2 <= por_s1;
    end
  end

  // Counter only runs while the synced level disagrees with the debounced one.
  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      dev_det  <= 1'b0;
      dbnc_cnt <= '0;
    end else if (det_s2 != dev_det) begin
      if (dbnc_cnt == DW'(DBNC_CYC - 1)) begin
        dev_det  <= ~dev_det;
        dbnc_cnt <= '0;
      end else begin
        dbnc_cnt <= dbnc_cnt + DW'(1);
      end
    end else begin
      dbnc_cnt <= '0;
    end
  end

  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      state    <= S_RESET;
      ch_idx   <= '0;
      slot_cnt <= '0;
      released <= '0;
    end else begin
      state    <= state_nxt;
      ch_idx   <= ch_idx_nxt;
      slot_cnt <= slot_nxt;
      released <= released_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ch_idx_nxt   = ch_idx;
    slot_nxt     = slot_cnt;
    released_nxt = released;
    case (state)
      S_RESET:    state_nxt = S_WAIT_DET;
      S_WAIT_DET: if (dev_det) state_nxt = S_WAIT_POR;
      S_WAIT_POR, S_RELEASE, S_DONE: begin
        // Detect loss outranks a POR re-assertion on the same cycle.
        if (!dev_det) begin
          state_nxt    = S_WAIT_DET;
          released_nxt = '0;
        end else if (state == S_WAIT_POR) begin
          if (!por_s2) begin
            state_nxt  = S_RELEASE;
            ch_idx_nxt = '0;
            slot_nxt   = '0;
          end
        end else if (por_s2) begin
          state_nxt    = S_WAIT_POR;
          released_nxt = '0;
        end else if (state == S_RELEASE) begin
          if (slot_cnt == SW'(STAGGER_CYC - 1)) begin
            for (int i = 0; i < NUM_CH; i++)
              if (ch_idx == CW'(i)) released_nxt[i] = i_ch_en[i];
            slot_nxt   = '0;
            ch_idx_nxt = ch_idx + CW'(1);
            if (ch_idx == CW'(NUM_CH - 1)) state_nxt = S_DONE;
          end else begin
            slot_nxt = slot_cnt + SW'(1);
          end
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

`ifdef AIBCR3AUX_POR_FAULT_STAT_EN
  logic       fault_q;
  logic [7:0] fault_cnt_q;
  logic       fault_evt;

  assign fault_evt = !dev_det &&
                     (state == S_WAIT_POR || state == S_RELEASE || state == S_DONE);

  always_ff @(posedge i_osc_clk) begin
    if (!i_rst_n) begin
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else if (fault_evt) begin
      fault_q <= 1'b1;
      if (fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign o_fault     = fault_q;
  assign o_fault_cnt = fault_cnt_q;
`else
  assign o_fault     = 1'b0;
  assign o_fault_cnt = 8'd0;
`endif

  assign osc_clkout    = i_osc_clk;
  assign o_por_vccl    = 1'b0;
  assign o_dev_det     = dev_det;
  assign o_state       = state;
  assign o_seq_done    = (state == S_DONE);
  assign o_por_vcchssi = m_por_ovrd &
                         (state == S_RESET || state == S_WAIT_DET || state == S_WAIT_POR);
  assign o_ch_por      = {NUM_CH{m_por_ovrd}} & ~released;
endmodule
